// File: rtl/convert_hsv2rgb.sv
// Pipelined HSV-to-RGB converter. One pixel per clock, fixed 5-cycle latency, no backpressure.
// Pipeline: input capture, hue normalisation, chroma, min/offset, mid, channel select.
// Optional macro HSV2RGB_ROUND_EN selects round-half-up scaling; the default build truncates.
module convert_hsv2rgb (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  h_s_data,
  input  logic [7:0]  s_s_data,
  input  logic [7:0]  v_s_data,
  input  logic        hsv_s_valid,
  output logic [23:0] rgb_m_data,
  output logic        rgb_m_valid
);

  // Input capture
  logic [7:0]  h0_d, h0_q, s0_d, s0_q, v0_d, v0_q;
  logic        vld0_d, vld0_q;
  // Stage 1: hue normalisation
  logic [2:0]  sec1_d, sec1_q;
  logic [5:0]  q1_d, q1_q;
  logic [7:0]  s1_d, s1_q, v1_d, v1_q;
  // Stage 2: chroma
  logic [7:0]  diff2_d, diff2_q, v2_d, v2_q;
  logic [5:0]  q2_d, q2_q;
  logic [2:0]  sec2_d, sec2_q;
  // Stage 3: min and offset
  logic [7:0]  min3_d, min3_q, off3_d, off3_q, v3_d, v3_q;
  logic [2:0]  sec3_d, sec3_q;
  // Stage 4: mid
  logic [7:0]  mid4_d, mid4_q, min4_d, min4_q, v4_d, v4_q;
  logic [2:0]  sec4_d, sec4_q;
  // Stage 5: channel assignment
  logic [23:0] rgb5_d, rgb5_q;
  // Valid shift register, aligned with stages 1..5
  logic [4:0]  vld_sr_d, vld_sr_q;

  // Capture raw inputs; this register is the sampling point for latency counting
  always_comb begin
    h0_d   = h_s_data;
    s0_d   = s_s_data;
    v0_d   = v_s_data;
    vld0_d = hsv_s_valid;
  end

  // Stage 1: fold hue into 0..191, split into sextant and ramp position
  always_comb begin
    logic [7:0] hn;
    logic [4:0] f;
    hn     = (h0_q >= 8'd192) ? (h0_q - 8'd192) : h0_q;
    f      = hn[4:0];
    sec1_d = hn[7:5];
    // Odd sextants ramp downwards
    q1_d   = sec1_d[0] ? (6'd32 - {1'b0, f}) : {1'b0, f};
    s1_d   = s0_q;
    v1_d   = v0_q;
  end

  // Stage 2: chroma diff = s*v/256
  always_comb begin
    logic [15:0] prod;
`ifdef HSV2RGB_ROUND_EN
    logic [16:0] sum;
    logic [8:0]  r9;
`endif
    prod = 16'(s1_q) * 16'(v1_q);
`ifdef HSV2RGB_ROUND_EN
    sum  = 17'(prod) + 17'd128;
    r9   = 9'(sum >> 8);
    // Rounding can only push diff past v by one code; clamp it back
    diff2_d = (r9 > {1'b0, v1_q}) ? v1_q : r9[7:0];
`else
    diff2_d = 8'(prod >> 8);
`endif
    v2_d   = v1_q;
    q2_d   = q1_q;
    sec2_d = sec1_q;
  end

  // Stage 3: min = v - diff, off = diff*q/32
  always_comb begin
    logic [13:0] prod;
`ifdef HSV2RGB_ROUND_EN
    logic [14:0] sum;
    logic [9:0]  o10;
`endif
    prod   = 14'(diff2_q) * 14'(q2_q);
    min3_d = v2_q - diff2_q;
`ifdef HSV2RGB_ROUND_EN
    sum    = 15'(prod) + 15'd16;
    o10    = 10'(sum >> 5);
    off3_d = (o10 > {2'b00, diff2_q}) ? diff2_q : o10[7:0];
`else
    off3_d = 8'(prod >> 5);
`endif
    v3_d   = v2_q;
    sec3_d = sec2_q;
  end

  // Stage 4: mid = min + off, bounded by v since off <= diff
  always_comb begin
    mid4_d = min3_q + off3_q;
    min4_d = min3_q;
    v4_d   = v3_q;
    sec4_d = sec3_q;
  end

  // Stage 5: route max/mid/min onto R,G,B according to sextant
  always_comb begin
    rgb5_d = {v4_q, v4_q, v4_q};
    case (sec4_q)
      3'd0:    rgb5_d = {v4_q,   mid4_q, min4_q};
      3'd1:    rgb5_d = {mid4_q, v4_q,   min4_q};
      3'd2:    rgb5_d = {min4_q, v4_q,   mid4_q};
      3'd3:    rgb5_d = {min4_q, mid4_q, v4_q};
      3'd4:    rgb5_d = {mid4_q, min4_q, v4_q};
      3'd5:    rgb5_d = {v4_q,   min4_q, mid4_q};
      default: rgb5_d = {v4_q, v4_q, v4_q};
    endcase
  end

  // Valid advances every cycle alongside the data, valid or not
  always_comb begin
    vld_sr_d = {vld_sr_q[3:0], vld0_q};
  end

  // All pipeline state; reset discards everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h0_q     <= '0;
      s0_q     <= '0;
      v0_q     <= '0;
      vld0_q   <= 1'b0;
      sec1_q   <= '0;
      q1_q     <= '0;
      s1_q     <= '0;
      v1_q     <= '0;
      diff2_q  <= '0;
      v2_q     <= '0;
      q2_q     <= '0;
      sec2_q   <= '0;
      min3_q   <= '0;
      off3_q   <= '0;
      v3_q     <= '0;
      sec3_q   <= '0;
      mid4_q   <= '0;
      min4_q   <= '0;
      v4_q     <= '0;
      sec4_q   <= '0;
      rgb5_q   <= '0;
      vld_sr_q <= '0;
    end else begin
      h0_q     <= h0_d;
      s0_q     <= s0_d;
      v0_q     <= v0_d;
      vld0_q   <= vld0_d;
      sec1_q   <= sec1_d;
      q1_q     <= q1_d;
      s1_q     <= s1_d;
      v1_q     <= v1_d;
      diff2_q  <= diff2_d;
      v2_q     <= v2_d;
      q2_q     <= q2_d;
      sec2_q   <= sec2_d;
      min3_q   <= min3_d;
      off3_q   <= off3_d;
      v3_q     <= v3_d;
      sec3_q   <= sec3_d;
      mid4_q   <= mid4_d;
      min4_q   <= min4_d;
      v4_q     <= v4_d;
      sec4_q   <= sec4_d;
      rgb5_q   <= rgb5_d;
      vld_sr_q <= vld_sr_d;
    end
  end

  assign rgb_m_data  = rgb5_q;
  assign rgb_m_valid = vld_sr_q[4];

endmodule

// File: tb/tb_convert_hsv2rgb.sv
// Bench for convert_hsv2rgb: directed vectors, a streaming run with a gap, and mid-stream reset.
module tb_convert_hsv2rgb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  h_s_data = '0;
  logic [7:0]  s_s_data = '0;
  logic [7:0]  v_s_data = 8'd255;
  logic        hsv_s_valid = 1'b0;
  logic [23:0] rgb_m_data;
  logic        rgb_m_valid;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  convert_hsv2rgb dut (
    .clk        (clk),
    .reset      (reset),
    .h_s_data   (h_s_data),
    .s_s_data   (s_s_data),
    .v_s_data   (v_s_data),
    .hsv_s_valid(hsv_s_valid),
    .rgb_m_data (rgb_m_data),
    .rgb_m_valid(rgb_m_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion written straight from the arithmetic definition
  function automatic logic [23:0] model(input logic [7:0] h, input logic [7:0] s,
                                        input logic [7:0] v);
    int hn, sec, f, q, diff, mn, off, mid, r, g, b;
    hn  = (h >= 192) ? int'(h) - 192 : int'(h);
    sec = hn / 32;
    f   = hn % 32;
    q   = (sec % 2 == 1) ? 32 - f : f;
`ifdef HSV2RGB_ROUND_EN
    diff = (int'(s) * int'(v) + 128) / 256;
    if (diff > int'(v)) diff = int'(v);
    off = (diff * q + 16) / 32;
    if (off > diff) off = diff;
`else
    diff = (int'(s) * int'(v)) / 256;
    off  = (diff * q) / 32;
`endif
    mn  = int'(v) - diff;
    mid = mn + off;
    case (sec)
      0: begin r = v;   g = mid; b = mn;  end
      1: begin r = mid; g = v;   b = mn;  end
      2: begin r = mn;  g = v;   b = mid; end
      3: begin r = mn;  g = mid; b = v;   end
      4: begin r = mid; g = mn;  b = v;   end
      default: begin r = v; g = mn; b = mid; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Drive one valid pixel; sampled on the next edge, due 5 edges after that
  task automatic drive(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                       input logic [23:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    h_s_data    = h;
    s_s_data    = s;
    v_s_data    = v;
    hsv_s_valid = 1'b1;
    e.rgb = exp;
    e.due = cyc + 6;
    sb.push_back(e);
  endtask

  // Directed vector: fixed expectation for truncation, model when rounding is built in
  task automatic drive_dir(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                           input logic [23:0] exp_trunc);
`ifdef HSV2RGB_ROUND_EN
    drive(h, s, v, model(h, s, v));
`else
    drive(h, s, v, exp_trunc);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      hsv_s_valid = 1'b0;
      h_s_data    = 8'd0;
      s_s_data    = 8'd0;
      v_s_data    = 8'd255;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_bad++;
      $error("FAIL drain: %0d outputs still pending, want 0", sb.size());
    end
  endtask

  // Output monitor: every cycle either nothing is due and valid is low, or the head is checked
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sb.size() == 0) begin
        n_cmp++;
        assert (rgb_m_valid === 1'b0)
        else begin
          n_bad++;
          $error("FAIL spurious_valid: got valid=%b data=%h, want valid=0", rgb_m_valid,
                 rgb_m_data);
        end
      end else if (rgb_m_valid === 1'b1 || sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        assert (rgb_m_valid === 1'b1 && cyc == e.due)
        else begin
          n_bad++;
          $error("FAIL timing: got valid=%b at cycle %0d, want valid=1 at cycle %0d",
                 rgb_m_valid, cyc, e.due);
        end
        if (rgb_m_valid === 1'b1) begin
          n_cmp++;
          assert (rgb_m_data === e.rgb)
          else begin
            n_bad++;
            $error("FAIL data: got %h, want %h", rgb_m_data, e.rgb);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] h, s, v;

    // Reset state
    #1;
    n_cmp++;
    assert (rgb_m_valid === 1'b0)
    else begin n_bad++; $error("FAIL reset_valid: got %b, want 0", rgb_m_valid); end
    n_cmp++;
    assert (rgb_m_data === 24'h000000)
    else begin n_bad++; $error("FAIL reset_data: got %h, want 000000", rgb_m_data); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors
    drive_dir(8'd0,   8'd255, 8'd255, 24'hFF0101);
    drive_dir(8'd192, 8'd255, 8'd255, 24'hFF0101);
    drive_dir(8'd16,  8'd128, 8'd200, 24'hC89664);
    drive_dir(8'd112, 8'd128, 8'd200, 24'h6496C8);
    drive_dir(8'd200, 8'd255, 8'd255, 24'hFF4001);
    drive_dir(8'd32,  8'd255, 8'd255, 24'hFFFF01);
    drive_dir(8'd100, 8'd0,   8'd128, 24'h808080);
    drive_dir(8'd77,  8'd201, 8'd0,   24'h000000);
    drive_dir(8'd250, 8'd33,  8'd0,   24'h000000);
`ifdef HSV2RGB_ROUND_EN
    drive(8'd16, 8'd129, 8'd201, 24'hC99764);
`else
    drive(8'd16, 8'd129, 8'd201, 24'hC99664);
`endif
    idle(1);
    drain();

    // 20 back-to-back pixels with a 3-cycle gap after the tenth
    for (int i = 0; i < 20; i++) begin
      if (i == 10) idle(3);
      h = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      v = 8'($urandom_range(0, 255));
      drive(h, s, v, model(h, s, v));
    end
    idle(1);
    drain();

    // Mid-stream reset with three pixels in flight
    idle(8);
    drive(8'd40, 8'd200, 8'd180, model(8'd40, 8'd200, 8'd180));
    drive(8'd90, 8'd150, 8'd220, model(8'd90, 8'd150, 8'd220));
    drive(8'd170, 8'd255, 8'd99, model(8'd170, 8'd255, 8'd99));
    @(posedge clk);
    #3;
    hsv_s_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    #1;
    n_cmp++;
    assert (rgb_m_valid === 1'b0)
    else begin n_bad++; $error("FAIL midreset_valid: got %b, want 0", rgb_m_valid); end
    n_cmp++;
    assert (rgb_m_data === 24'h000000)
    else begin n_bad++; $error("FAIL midreset_data: got %h, want 000000", rgb_m_data); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);

    // First pixel after reset keeps the 5-cycle latency
    drive_dir(8'd16, 8'd128, 8'd200, 24'hC89664);
    idle(1);
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
